// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, flag and prefetch controller that turns one sc_ram into a
// show-ahead (first-word-fall-through) synchronous FIFO. RAM reads are issued
// as soon as data and buffer space exist. Returning words land in a small
// register FIFO, so the head word is already waiting at rd_data_o.
//
// Ports
//   clk_i, rst_ni       clock (rising edge) and asynchronous active-low reset
//   wr_data_i/wr_req_i  producer write word and request (accepted when !full_o)
//   full_o              RAM holds 2**AWIDTH words
//   rd_data_o/rd_valid_o head word and its valid flag
//   rd_ack_i            consumer takes the head word (ignored when !rd_valid_o)
//   usedw_o             total words held: RAM + reads in flight + output buffer
//   ovf_o/udf_o         write-while-full / ack-while-empty pulses
//   ram_*               straight connections to the sc_ram write and read ports
module fifo_ctrl #(
    parameter int DWIDTH          = 64,
    parameter int AWIDTH          = 10,
    parameter int REGISTER_OUTPUT = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              wr_req_i,
    output logic              full_o,
    output logic [DWIDTH-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ack_i,
    output logic [AWIDTH+1:0] usedw_o,
    output logic              ovf_o,
    output logic              udf_o,
    output logic [DWIDTH-1:0] ram_wr_data_o,
    output logic [AWIDTH-1:0] ram_wr_addr_o,
    output logic              ram_wr_en_o,
    output logic [AWIDTH-1:0] ram_rd_addr_o,
    output logic              ram_rd_en_o,
    input  logic [DWIDTH-1:0] ram_rd_data_i
);

    localparam int L         = 1 + REGISTER_OUTPUT;
    localparam int BUF_DEPTH = L + 2;
    localparam int BW        = $clog2(BUF_DEPTH);
    localparam int BUF_SLOTS = 1 << BW;
    localparam int CW        = BW + 1;
    localparam int UW        = AWIDTH + 2;

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [L-1:0]      trk_q, trk_d;
    logic [L:0]        trk_ext;
    logic [BW-1:0]     buf_head_q, buf_head_d;
    logic [BW-1:0]     buf_tail_q, buf_tail_d;
    logic [CW-1:0]     buf_cnt_q, buf_cnt_d;
    logic [DWIDTH-1:0] buf_mem_q [BUF_SLOTS];
    logic [CW-1:0]     inflight;

    logic wr_en, issue, push, pop;

    // Buffer index advance with wrap at BUF_DEPTH, which need not be a power of two.
    function automatic logic [BW-1:0] bump(input logic [BW-1:0] p);
        return (p == BW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reads in flight are the set bits of the tracking shift register.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < L; i++) begin
            inflight = inflight + CW'(trk_q[i]);
        end
    end

    assign full_o = (ram_cnt_q == (AWIDTH+1)'(1 << AWIDTH));
    assign wr_en  = wr_req_i & ~full_o;

    // Issue only when a buffer slot is guaranteed for the returning word.
    // Because ram_cnt_q is registered, a word written at one edge is never
    // read from the same address in the same cycle.
    assign issue  = (ram_cnt_q != '0) && ((inflight + buf_cnt_q) < CW'(BUF_DEPTH));
    assign push   = trk_q[L-1];
    assign pop    = rd_ack_i & rd_valid_o;

    assign ram_wr_en_o   = wr_en;
    assign ram_wr_addr_o = wr_ptr_q;
    assign ram_wr_data_o = wr_data_i;
    assign ram_rd_addr_o = rd_ptr_q;
    // With the registered RAM output the address stage samples every cycle;
    // the strobe only needs to gate the output stage one cycle later.
    assign ram_rd_en_o   = (L == 1) ? issue : trk_q[0];

    assign rd_valid_o = (buf_cnt_q != '0);
    assign rd_data_o  = rd_valid_o ? buf_mem_q[buf_head_q] : '0;
    assign usedw_o    = UW'(ram_cnt_q) + UW'(inflight) + UW'(buf_cnt_q);
    assign ovf_o      = wr_req_i & full_o;
    assign udf_o      = rd_ack_i & ~rd_valid_o;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        buf_head_d = buf_head_q;
        buf_tail_d = buf_tail_q;
        buf_cnt_d  = buf_cnt_q;
        trk_ext    = {trk_q, issue};
        trk_d      = trk_ext[L-1:0];

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        if (push) buf_tail_d = bump(buf_tail_q);
        if (pop)  buf_head_d = bump(buf_head_q);
        case ({push, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 1'b1;
            2'b01:   buf_cnt_d = buf_cnt_q - 1'b1;
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            trk_q      <= '0;
            buf_head_q <= '0;
            buf_tail_q <= '0;
            buf_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            trk_q      <= trk_d;
            buf_head_q <= buf_head_d;
            buf_tail_q <= buf_tail_d;
            buf_cnt_q  <= buf_cnt_d;
        end
    end

    // Buffer storage carries no reset; rd_data_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) buf_mem_q[buf_tail_q] <= ram_rd_data_i;
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: two instances (RAM latency 1 and 2, AWIDTH=4) share one
// stimulus stream, each with its own sc_ram model and scoreboard monitor.
module tb_fifo_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] wr_data;
    logic          wr_req;
    logic          rd_ack;

    logic          full_w   [2];
    logic [DW-1:0] rdd_w    [2];
    logic          rdv_w    [2];
    logic [AW+1:0] usedw_w  [2];
    logic          ovf_w    [2];
    logic          udf_w    [2];
    logic          ram_we_w [2];
    logic          ram_re_w [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [DW-1:0] ram_wd, ram_rdat;
        logic [AW-1:0] ram_wa, ram_ra, ra_q;
        logic [DW-1:0] mem [2**AW];

        fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .REGISTER_OUTPUT(g)) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .wr_data_i     (wr_data),
            .wr_req_i      (wr_req),
            .full_o        (full_w[g]),
            .rd_data_o     (rdd_w[g]),
            .rd_valid_o    (rdv_w[g]),
            .rd_ack_i      (rd_ack),
            .usedw_o       (usedw_w[g]),
            .ovf_o         (ovf_w[g]),
            .udf_o         (udf_w[g]),
            .ram_wr_data_o (ram_wd),
            .ram_wr_addr_o (ram_wa),
            .ram_wr_en_o   (ram_we_w[g]),
            .ram_rd_addr_o (ram_ra),
            .ram_rd_en_o   (ram_re_w[g]),
            .ram_rd_data_i (ram_rdat)
        );

        // sc_ram model: latency 1 reads the address directly; latency 2 has an
        // always-sampling address stage and an output stage gated by rd_en.
        always @(posedge clk) begin
            if (ram_we_w[g]) mem[ram_wa] <= ram_wd;
            ra_q <= ram_ra;
            if (ram_re_w[g]) ram_rdat <= (g == 0) ? mem[ram_ra] : mem[ra_q];
        end

        // Scoreboard monitor: accepted writes are queued, consumed words are
        // compared in order, and occupancy/pulses are checked every cycle.
        initial begin
            logic [DW-1:0] exp_q [$];
            logic [DW-1:0] pd;
            logic [DW-1:0] want;
            int cnt_m;
            logic pv, pa;
            cnt_m = 0;
            pv = 1'b0;
            pa = 1'b0;
            pd = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_q.delete();
                    cnt_m = 0;
                    pv = 1'b0;
                end else begin
                    check($sformatf("usedw[%0d]", g), 64'(usedw_w[g]), 64'(cnt_m));
                    check($sformatf("ovf[%0d]", g), 64'(ovf_w[g]), 64'(wr_req && full_w[g]));
                    check($sformatf("udf[%0d]", g), 64'(udf_w[g]), 64'(rd_ack && !rdv_w[g]));
                    if (pv && !pa && rdv_w[g])
                        check($sformatf("stable[%0d]", g), 64'(rdd_w[g]), 64'(pd));
                    if (wr_req && !full_w[g]) begin
                        exp_q.push_back(wr_data);
                        cnt_m++;
                    end
                    if (rdv_w[g] && rd_ack) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL pop_empty[%0d] got=%0h want=none", g, rdd_w[g]);
                        end else begin
                            want = exp_q.pop_front();
                            check($sformatf("data[%0d]", g), 64'(rdd_w[g]), 64'(want));
                        end
                        cnt_m--;
                    end
                    pv = rdv_w[g];
                    pa = rd_ack;
                    pd = rdd_w[g];
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_full[%0d]", tag, g), 64'(full_w[g]), 64'd0);
            check($sformatf("%s_valid[%0d]", tag, g), 64'(rdv_w[g]), 64'd0);
            check($sformatf("%s_usedw[%0d]", tag, g), 64'(usedw_w[g]), 64'd0);
            check($sformatf("%s_ovf[%0d]", tag, g), 64'(ovf_w[g]), 64'd0);
            check($sformatf("%s_udf[%0d]", tag, g), 64'(udf_w[g]), 64'd0);
            check($sformatf("%s_ramwe[%0d]", tag, g), 64'(ram_we_w[g]), 64'd0);
            check($sformatf("%s_ramre[%0d]", tag, g), 64'(ram_re_w[g]), 64'd0);
            check($sformatf("%s_rdata[%0d]", tag, g), 64'(rdd_w[g]), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        rd_ack  = 1'b0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1 rst_n = 1'b1;

        // Single write of 0xA5: valid appears 2+L cycles later.
        @(posedge clk); #1 wr_req = 1'b1; wr_data = 16'h00A5;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1 wr_req = 1'b0;
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check($sformatf("lat_valid[%0d]c%0d", g, c), 64'(rdv_w[g]), 64'(c >= 3 + g));
                if (c == 3 + g) check($sformatf("lat_data[%0d]", g), 64'(rdd_w[g]), 64'h00A5);
            end
        end
        @(posedge clk); #1 rd_ack = 1'b1;
        @(posedge clk); #1 rd_ack = 1'b0;
        repeat (3) @(posedge clk);

        // Fill without reads: 16 RAM words plus L+2 buffered words.
        for (int k = 0; k < 23; k++) begin
            @(posedge clk); #1 wr_req = 1'b1; wr_data = 16'(k);
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check($sformatf("fill_full[%0d]k%0d", g, k), 64'(full_w[g]), 64'(k >= 19 + g));
                check($sformatf("fill_ovf[%0d]k%0d", g, k), 64'(ovf_w[g]), 64'(k >= 19 + g));
            end
        end
        @(posedge clk); #1 wr_req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("fill_usedw[%0d]", g), 64'(usedw_w[g]), 64'(19 + g));
            check($sformatf("fill_full_hold[%0d]", g), 64'(full_w[g]), 64'd1);
        end

        // Drain with continuous ack: one word per cycle, full drops at cycle 2.
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1 rd_ack = 1'b1;
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check($sformatf("drain_valid[%0d]i%0d", g, i), 64'(rdv_w[g]), 64'(i < 19 + g));
                if (i < 4) check($sformatf("drain_full[%0d]i%0d", g, i), 64'(full_w[g]), 64'(i < 2));
            end
        end
        @(posedge clk); #1 rd_ack = 1'b0;
        repeat (3) @(posedge clk);

        // Streaming 48 words across three pointer wraps, ack from cycle 4.
        for (int c = 0; c < 52; c++) begin
            @(posedge clk); #1
            wr_req  = (c < 48);
            wr_data = 16'(16'h0100 + c);
            rd_ack  = (c >= 4);
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (c >= 4) check($sformatf("strm_valid[%0d]c%0d", g, c), 64'(rdv_w[g]), 64'd1);
                check($sformatf("strm_ovf[%0d]", g), 64'(ovf_w[g]), 64'd0);
                check($sformatf("strm_udf[%0d]", g), 64'(udf_w[g]), 64'd0);
            end
        end
        @(posedge clk); #1 wr_req = 1'b0; rd_ack = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++)
            check($sformatf("strm_empty[%0d]", g), 64'(usedw_w[g]), 64'd0);

        // Random traffic at 50% on both sides.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1
            wr_req  = 1'($urandom_range(0, 1));
            rd_ack  = 1'($urandom_range(0, 1));
            wr_data = 16'($urandom);
        end
        @(posedge clk); #1 wr_req = 1'b0; rd_ack = 1'b1;
        repeat (40) @(posedge clk);
        #1 rd_ack = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rnd_usedw[%0d]", g), 64'(usedw_w[g]), 64'd0);
            check($sformatf("rnd_valid[%0d]", g), 64'(rdv_w[g]), 64'd0);
        end

        // Reset in the middle of activity: 5 words stored, reads in flight.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1 wr_req = 1'b1; wr_data = 16'(16'h0200 + c);
        end
        @(posedge clk); #1 wr_req = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 wr_req = 1'b1; wr_data = 16'h0077;
        @(posedge clk); #1 wr_req = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            ok = rdv_w[0] && rdv_w[1];
        end
        check("post_rst_valid", 64'(ok), 64'd1);
        for (int g = 0; g < 2; g++)
            check($sformatf("post_rst_data[%0d]", g), 64'(rdd_w[g]), 64'h0077);
        @(posedge clk); #1 rd_ack = 1'b1;
        @(posedge clk); #1 rd_ack = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
